run_detect_param: RTL and testbench

- Parametrised successor to the single-threshold run detector.
- On a capture strobe it latches a threshold, run length and polarity from its inputs.
- It then counts runs: each run is run_len consecutive samples strictly beyond the threshold.
- Adds programmable run length, above/below polarity, re-arm hysteresis, a saturating counter with sticky overflow, a count clear and a per-run pulse. Sits in the signal-monitor path between the sample source and status registers.

---
 rtl/run_detect_param.sv | 155 +++++++++++++++
 tb/tb_run_detect_param.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_detect_param.sv
// run_detect_param: parametrised run detector for the signal-monitor path.
// A capture strobe latches the threshold, run length and polarity. After that,
// every run of L consecutive qualifying samples (strictly beyond thr in the
// selected direction) counts once. The detector then waits for a re-arm sample
// outside the hysteresis band before it searches again.
//
// Ports:
//   clk          system clock, all state updates on rising edge
//   rst          synchronous active-high reset
//   strt_cap_cmp capture strobe: latch sig/run_len/mode_below, enter SEARCH
//   sig          sample, one per clock
//   run_len      required run length (0 is treated as 1), sampled on capture
//   mode_below   polarity, sampled on capture: 0 = sig > thr, 1 = sig < thr
//   clr_cnt      clear n_run and ovf
//   n_run        completed-run count, saturating
//   run_pulse    one-cycle pulse per completed run
//   armed        high while in SEARCH
//   ovf          sticky: a run completed while n_run was all-ones
//   thr          captured threshold
module run_detect_param #(
  parameter int DATA_W = 4,
  parameter int RL_W   = 4,
  parameter int CNT_W  = 4,
  parameter int HYST   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strt_cap_cmp,
  input  logic [DATA_W-1:0] sig,
  input  logic [RL_W-1:0]   run_len,
  input  logic              mode_below,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  n_run,
  output logic              run_pulse,
  output logic              armed,
  output logic              ovf,
  output logic [DATA_W-1:0] thr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic [DATA_W:0] HYST_X = HYST[DATA_W:0];
  localparam logic [DATA_W:0] DMAX_X = {1'b0, {DATA_W{1'b1}}};
  localparam logic [RL_W:0]   ONE_R  = 1;
  localparam logic [RL_W-1:0] ONE_L  = 1;
  localparam logic [CNT_W-1:0] ONE_C = 1;

  typedef struct packed {
    logic [DATA_W-1:0] thr;
    logic [RL_W-1:0]   len;
    logic              below;
  } cfg_t;

  logic [1:0]       state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [RL_W-1:0]  rc_q, rc_d;
  logic [CNT_W-1:0] n_run_q, n_run_d;
  logic             ovf_q, ovf_d;
  logic             pulse_q, pulse_d;
  logic             armed_q;

  // Predicates are evaluated one bit wider so the hysteresis band edges can be
  // clamped to the sample range instead of wrapping.
  logic [DATA_W:0] sig_x, thr_x, lo_x, hi_sum, hi_x;
  logic            qual, rearm, done;
  logic [RL_W:0]   rc_inc;

  always_comb begin
    sig_x  = {1'b0, sig};
    thr_x  = {1'b0, cfg_q.thr};
    lo_x   = (thr_x >= HYST_X) ? (thr_x - HYST_X) : '0;
    hi_sum = thr_x + HYST_X;
    hi_x   = (hi_sum > DMAX_X) ? DMAX_X : hi_sum;
    qual   = cfg_q.below ? (sig < cfg_q.thr) : (sig > cfg_q.thr);
    rearm  = cfg_q.below ? (sig_x >= hi_x) : (sig_x <= lo_x);
    rc_inc = {1'b0, rc_q} + ONE_R;
    done   = qual && (rc_inc == {1'b0, cfg_q.len});
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    rc_d    = rc_q;
    n_run_d = n_run_q;
    ovf_d   = ovf_q;
    pulse_d = 1'b0;
    if (strt_cap_cmp) begin
      // Capture cycle's sample is only latched, never evaluated.
      cfg_d.thr   = sig;
      cfg_d.len   = (run_len == '0) ? ONE_L : run_len;
      cfg_d.below = mode_below;
      rc_d        = '0;
      n_run_d     = '0;
      ovf_d       = 1'b0;
      state_d     = SEARCH;
    end else begin
      case (state_q)
        SEARCH: begin
          if (done) begin
            pulse_d = 1'b1;
            rc_d    = '0;
            state_d = HOLD;
            if (&n_run_q) ovf_d = 1'b1;
            else          n_run_d = n_run_q + ONE_C;
          end else if (qual) begin
            rc_d = rc_inc[RL_W-1:0];
          end else begin
            rc_d = '0;
          end
        end
        HOLD: begin
          if (rearm) begin
            rc_d    = '0;
            state_d = SEARCH;
          end
        end
        default: ;
      endcase
      // Clear wins over a same-cycle completion; the pulse still fires.
      if (clr_cnt) begin
        n_run_d = '0;
        ovf_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_q   <= '{thr: '0, len: ONE_L, below: 1'b0};
      rc_q    <= '0;
      n_run_q <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      rc_q    <= rc_d;
      n_run_q <= n_run_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
      armed_q <= (state_d == SEARCH);
    end
  end

  assign n_run     = n_run_q;
  assign run_pulse = pulse_q;
  assign armed     = armed_q;
  assign ovf       = ovf_q;
  assign thr       = cfg_q.thr;

endmodule

// File: tb/tb_run_detect_param.sv
module tb_run_detect_param;
  logic       clk;
  logic       rst;
  logic       strt_cap_cmp;
  logic [3:0] sig;
  logic [3:0] run_len;
  logic       mode_below;
  logic       clr_cnt;
  logic [3:0] n_run_o [2];
  logic       pulse_o [2];
  logic       armed_o [2];
  logic       ovf_o   [2];
  logic [3:0] thr_o   [2];

  int errors = 0;
  int checks = 0;

  // u0: HYST=0, u1: HYST=2; both see the same stimulus.
  run_detect_param u0 (
    .clk(clk), .rst(rst), .strt_cap_cmp(strt_cap_cmp), .sig(sig), .run_len(run_len),
    .mode_below(mode_below), .clr_cnt(clr_cnt), .n_run(n_run_o[0]), .run_pulse(pulse_o[0]),
    .armed(armed_o[0]), .ovf(ovf_o[0]), .thr(thr_o[0]));
  run_detect_param #(.HYST(2)) u1 (
    .clk(clk), .rst(rst), .strt_cap_cmp(strt_cap_cmp), .sig(sig), .run_len(run_len),
    .mode_below(mode_below), .clr_cnt(clr_cnt), .n_run(n_run_o[1]), .run_pulse(pulse_o[1]),
    .armed(armed_o[1]), .ovf(ovf_o[1]), .thr(thr_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: "active" once captured, "waiting" after a run
  // until a sample leaves the hysteresis band, "streak" = consecutive qualifiers.
  int  m_hyst [2] = '{0, 2};
  bit  m_on   [2];
  bit  m_wait [2];
  int  m_streak [2];
  int  m_thr [2];
  int  m_L   [2];
  bit  m_below [2];
  int  m_n   [2];
  bit  m_ovf [2];
  bit  m_pulse [2];

  task automatic model_step(input int s, input bit st, input int rl, input bit mb,
                            input bit cl, input bit r);
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = 0;
      if (r) begin
        m_on[i] = 0; m_wait[i] = 0; m_streak[i] = 0; m_thr[i] = 0;
        m_L[i] = 1; m_below[i] = 0; m_n[i] = 0; m_ovf[i] = 0;
      end else if (st) begin
        m_thr[i] = s; m_L[i] = (rl == 0) ? 1 : rl; m_below[i] = mb;
        m_n[i] = 0; m_ovf[i] = 0; m_streak[i] = 0; m_on[i] = 1; m_wait[i] = 0;
      end else begin
        if (m_on[i]) begin
          bit q;
          int lo, hi;
          q  = m_below[i] ? (s < m_thr[i]) : (s > m_thr[i]);
          lo = m_thr[i] - m_hyst[i]; if (lo < 0) lo = 0;
          hi = m_thr[i] + m_hyst[i]; if (hi > 15) hi = 15;
          if (m_wait[i]) begin
            if (m_below[i] ? (s >= hi) : (s <= lo)) m_wait[i] = 0;
          end else if (q) begin
            m_streak[i]++;
            if (m_streak[i] == m_L[i]) begin
              m_pulse[i] = 1; m_streak[i] = 0; m_wait[i] = 1;
              if (m_n[i] == 15) m_ovf[i] = 1; else m_n[i]++;
            end
          end else m_streak[i] = 0;
        end
        if (cl) begin m_n[i] = 0; m_ovf[i] = 0; end
      end
    end
  endtask

  // Drive one cycle from a negedge; returns at the next negedge.
  task automatic drive(input logic [3:0] s, input logic st, input logic [3:0] rl,
                       input logic mb, input logic cl, input logic r);
    sig = s; strt_cap_cmp = st; run_len = rl; mode_below = mb; clr_cnt = cl; rst = r;
    model_step(int'(s), st, int'(rl), mb, cl, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic smp(input logic [3:0] s);
    drive(s, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (n_run_o[i] !== 4'd0 || pulse_o[i] !== 1'b0 || armed_o[i] !== 1'b0 ||
          ovf_o[i] !== 1'b0 || thr_o[i] !== 4'd0) begin
        errors++;
        $display("FAIL reset[%0d]: n=%0d p=%b a=%b o=%b thr=%0d, want all 0",
                 i, n_run_o[i], pulse_o[i], armed_o[i], ovf_o[i], thr_o[i]);
      end
    end
  endtask

  task automatic test_above();
    logic [3:0] a[4] = '{4'd6, 4'd8, 4'd9, 4'd3};
    logic [3:0] b[4] = '{4'd6, 4'd8, 4'd9, 4'd7};
    drive(4'd5, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    checks++;
    if (armed_o[0] !== 1'b1 || thr_o[0] !== 4'd5) begin
      errors++; $display("FAIL above_cap: armed=%b thr=%0d want 1/5", armed_o[0], thr_o[0]);
    end
    foreach (a[k]) smp(a[k]);
    checks++;
    if (n_run_o[0] !== 4'd0) begin
      errors++; $display("FAIL above_broken: n_run=%0d want 0", n_run_o[0]);
    end
    foreach (b[k]) begin
      smp(b[k]);
      if (k < 3) begin
        checks++;
        if (pulse_o[0] !== 1'b0) begin
          errors++; $display("FAIL above_early_pulse: pulse=%b want 0", pulse_o[0]);
        end
      end
    end
    checks++;
    if (n_run_o[0] !== 4'd1 || pulse_o[0] !== 1'b1 || armed_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL above_run: n=%0d p=%b a=%b want 1/1/0", n_run_o[0], pulse_o[0], armed_o[0]);
    end
  endtask

  task automatic test_hold();
    logic [3:0] c[4] = '{4'd5, 4'd8, 4'd7, 4'd6};
    for (int k = 0; k < 7; k++) begin
      smp(4'hA);
      checks++;
      if (n_run_o[0] !== 4'd1 || armed_o[0] !== 1'b0 || pulse_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold_ignore: n=%0d a=%b p=%b want 1/0/0", n_run_o[0], armed_o[0], pulse_o[0]);
      end
    end
    foreach (c[k]) smp(c[k]);
    checks++;
    if (n_run_o[0] !== 4'd1 || armed_o[0] !== 1'b1) begin
      errors++; $display("FAIL hold_rearm: n=%0d a=%b want 1/1", n_run_o[0], armed_o[0]);
    end
    smp(4'd9);
    checks++;
    if (n_run_o[0] !== 4'd2 || pulse_o[0] !== 1'b1) begin
      errors++; $display("FAIL hold_second: n=%0d p=%b want 2/1", n_run_o[0], pulse_o[0]);
    end
  endtask

  task automatic test_below();
    drive(4'd8, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    smp(4'd3); smp(4'd4);
    checks++;
    if (n_run_o[0] !== 4'd1) begin
      errors++; $display("FAIL below_run: n_run=%0d want 1", n_run_o[0]);
    end
    smp(4'd2);
    checks++;
    if (n_run_o[0] !== 4'd1 || armed_o[0] !== 1'b0) begin
      errors++; $display("FAIL below_hold: n=%0d a=%b want 1/0", n_run_o[0], armed_o[0]);
    end
    smp(4'd9);
    checks++;
    if (armed_o[0] !== 1'b1) begin
      errors++; $display("FAIL below_rearm: armed=%b want 1", armed_o[0]);
    end
    smp(4'd0); smp(4'd1);
    checks++;
    if (n_run_o[0] !== 4'd2) begin
      errors++; $display("FAIL below_second: n_run=%0d want 2", n_run_o[0]);
    end
  endtask

  task automatic test_hyst();
    drive(4'd8, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    smp(4'd9);
    checks++;
    if (n_run_o[1] !== 4'd1) begin
      errors++; $display("FAIL hyst_run: n_run=%0d want 1", n_run_o[1]);
    end
    smp(4'd7); smp(4'd7);
    checks++;
    if (armed_o[1] !== 1'b0) begin
      errors++; $display("FAIL hyst_band: armed=%b want 0", armed_o[1]);
    end
    smp(4'd9);
    checks++;
    if (n_run_o[1] !== 4'd1 || n_run_o[0] !== 4'd2) begin
      errors++; $display("FAIL hyst_ignore: u1 n=%0d want 1, u0 n=%0d want 2", n_run_o[1], n_run_o[0]);
    end
    smp(4'd6);
    checks++;
    if (armed_o[1] !== 1'b1) begin
      errors++; $display("FAIL hyst_rearm: armed=%b want 1", armed_o[1]);
    end
    smp(4'd9);
    checks++;
    if (n_run_o[1] !== 4'd2 || n_run_o[0] !== 4'd3) begin
      errors++; $display("FAIL hyst_second: u1 n=%0d want 2, u0 n=%0d want 3", n_run_o[1], n_run_o[0]);
    end
  endtask

  task automatic test_saturation();
    drive(4'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      smp(4'd1);
      if (k == 14) begin
        checks++;
        if (n_run_o[0] !== 4'hF || ovf_o[0] !== 1'b0) begin
          errors++; $display("FAIL sat_full: n=%0d o=%b want 15/0", n_run_o[0], ovf_o[0]);
        end
      end
      smp(4'd0);
    end
    checks++;
    if (n_run_o[0] !== 4'hF || ovf_o[0] !== 1'b1) begin
      errors++; $display("FAIL sat_ovf: n=%0d o=%b want 15/1", n_run_o[0], ovf_o[0]);
    end
    drive(4'd1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (n_run_o[0] !== 4'd0 || ovf_o[0] !== 1'b0 || pulse_o[0] !== 1'b1 || armed_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL sat_clr: n=%0d o=%b p=%b a=%b want 0/0/1/0",
               n_run_o[0], ovf_o[0], pulse_o[0], armed_o[0]);
    end
  endtask

  task automatic test_recapture();
    logic [3:0] s[10] = '{4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1};
    drive(4'd0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    foreach (s[k]) smp(s[k]);
    checks++;
    if (n_run_o[0] !== 4'd3 || armed_o[0] !== 1'b1) begin
      errors++; $display("FAIL recap_pre: n=%0d a=%b want 3/1", n_run_o[0], armed_o[0]);
    end
    drive(4'd9, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
    checks++;
    if (n_run_o[0] !== 4'd0 || thr_o[0] !== 4'd9 || armed_o[0] !== 1'b1) begin
      errors++; $display("FAIL recap: n=%0d thr=%0d a=%b want 0/9/1", n_run_o[0], thr_o[0], armed_o[0]);
    end
  endtask

  task automatic test_rst_mid();
    smp(4'd10);
    drive(4'd10, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (n_run_o[0] !== 4'd0 || pulse_o[0] !== 1'b0 || armed_o[0] !== 1'b0 ||
        ovf_o[0] !== 1'b0 || thr_o[0] !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid: n=%0d p=%b a=%b o=%b thr=%0d want all 0",
               n_run_o[0], pulse_o[0], armed_o[0], ovf_o[0], thr_o[0]);
    end
    for (int k = 0; k < 5; k++) begin
      smp(4'd15);
      checks++;
      if (n_run_o[0] !== 4'd0 || pulse_o[0] !== 1'b0 || armed_o[0] !== 1'b0) begin
        errors++; $display("FAIL rst_idle: n=%0d p=%b a=%b want 0/0/0", n_run_o[0], pulse_o[0], armed_o[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      logic r, st, cl, mb;
      logic [3:0] s, rl;
      r  = ($urandom_range(0, 63) == 0);
      st = (c == 0) || ($urandom_range(0, 19) == 0);
      cl = ($urandom_range(0, 15) == 0);
      mb = 1'($urandom_range(0, 1));
      rl = 4'($urandom_range(0, 3));
      s  = 4'($urandom_range(0, 15));
      drive(s, st, rl, mb, cl, r);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (n_run_o[i] !== 4'(m_n[i]) || pulse_o[i] !== m_pulse[i] || ovf_o[i] !== m_ovf[i] ||
            armed_o[i] !== (m_on[i] && !m_wait[i]) || thr_o[i] !== 4'(m_thr[i])) begin
          errors++;
          $display("FAIL rand[%0d] cyc %0d: n=%0d p=%b o=%b a=%b thr=%0d want %0d/%b/%b/%b/%0d",
                   i, c, n_run_o[i], pulse_o[i], ovf_o[i], armed_o[i], thr_o[i],
                   m_n[i], m_pulse[i], m_ovf[i], m_on[i] && !m_wait[i], m_thr[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; strt_cap_cmp = 1'b0; sig = '0; run_len = '0; mode_below = 1'b0; clr_cnt = 1'b0;
    @(negedge clk);
    test_reset();
    test_above();
    test_hold();
    test_below();
    test_hyst();
    test_saturation();
    test_recapture();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
